router_pkt_tx: RTL and testbench
================================

# router_pkt_tx

Packet source that drives the router's input side: it buffers a payload written by a host, then emits one router packet with header, payload and parity, obeying the router's `busy` back-pressure. It sits in front of the 1x3 router top, feeding its `pkt_valid`/`data_in` and observing its `busy`. The same block serves as a synthesizable traffic generator for system-level benches.

## Interface
Parameters:
- `MAX_LEN`, 63: payload buffer depth in bytes; also the largest legal packet length.
- `IFG`, 2: idle clocks forced between the parity byte and the next `start` acceptance.

Ports:
- `clock`, input, 1: single clock; all logic is rising-edge.
- `reset`, input, 1: asynchronous, active-high reset.
- `wr_en`, input, 1: push `wr_data` into the payload buffer.
- `wr_data`, input, 8: payload byte.
- `start`, input, 1: launch a packet of all buffered bytes.
- `dest`, input, 2: destination port 0..2.
- `err_inject`, input, 1: sampled with `start`; corrupts the transmitted parity.
- `busy`, input, 1: router back-pressure.
- `pkt_valid`, output, 1: to router `pkt_valid`.
- `data_out`, output, 8: to router `data_in`.
- `count`, output, 6: number of bytes currently buffered.
- `buf_full`, output, 1: high when `count == MAX_LEN`.
- `tx_active`, output, 1: high in any state other than IDLE.
- `done`, output, 1: one-cycle pulse when the parity byte is transferred.
- `cmd_err`, output, 1: one-cycle pulse when a `start` is rejected.

## Operation
- FSM states: IDLE, HEADER, PAYLOAD, PARITY, GAP.
- Transfer rule: a byte is transferred at a rising edge where the FSM is in HEADER, PAYLOAD or PARITY and `busy == 0`.
- While `busy == 1`, `data_out` and `pkt_valid` hold their values.
- IDLE:
  - `wr_en` with `!buf_full` writes `wr_data` at index `count`, and `count` increments.
  - `wr_en` with `buf_full` is dropped.
  - `start` with `count == 0` or `dest == 2'b11` pulses `cmd_err` next cycle and stays in IDLE.
  - A legal `start` latches `dest` and `err_inject`, initialises the running parity to the header value, and moves to HEADER.
- HEADER: `data_out = {count, dest}`, `pkt_valid = 1`. On transfer, go to PAYLOAD with the read index at 0.
- PAYLOAD:
  - `data_out = buf[idx]`, `pkt_valid = 1`.
  - On each transfer, XOR the byte into the parity and increment `idx`.
  - On transfer of byte `count-1`, go to PARITY.
- PARITY:
  - `pkt_valid = 0`.
  - `data_out` = running parity, XORed with `8'h01` if `err_inject` was latched.
  - On transfer: pulse `done`, clear `count` to 0, and go to GAP.
- GAP: `data_out = 0`, `pkt_valid = 0`. After `IFG` clocks, go to IDLE.
- Parity is the 8-bit XOR of the header and all payload bytes.
- `wr_en` outside IDLE is ignored: the buffer is frozen during transmission.
- If `wr_en` and a legal `start` occur in the same cycle, `start` wins and the write is dropped. If the `start` is rejected, the write proceeds.

## Timing
- Reset values:
  - state IDLE
  - `pkt_valid` 0, `data_out` 8'h00
  - `count` 0, `buf_full` 0
  - `tx_active` 0, `done` 0, `cmd_err` 0
  - parity 0, `idx` 0
- All outputs are registered.
- The header appears on `data_out` in the cycle after the `start` edge.
- With `busy` held low, a packet of N payload bytes occupies N+2 consecutive cycles, followed by `IFG` GAP cycles.
- `start` is next accepted on the edge after the final GAP cycle.
- `busy` is sampled only at edges, with no combinational path to outputs; a `busy` rise holds the current byte.
- Reset asserted mid-packet: outputs return to reset values immediately, the buffer is emptied, and no `done` is issued.

## Structure
- Shared package `router_pkg` contains:
  - the state enum for IDLE, HEADER, PAYLOAD, PARITY and GAP;
  - `MAX_LEN`;
  - the constant `ADDR_INVALID = 2'b11`;
  - a header-pack function `{len[5:0], addr[1:0]}`.
- Sub-module `router_tx_buf`: `MAX_LEN`×8 register array with a write-count pointer, asynchronous read by index, and a synchronous clear.
- The FSM and parity logic live in `router_pkt_tx`.

## Test plan
- Basic packet: write A1, B2, C3, then `start` with `dest=1` and `busy=0`.
  - Expect `data_out` sequence 0D, A1, B2, C3 with `pkt_valid=1`.
  - Then DD with `pkt_valid=0`, and a `done` pulse.
  - `count` returns to 0.
- Back-pressure: same packet with `busy` high for 3 cycles while on B2.
  - B2 is held for 4 cycles, with no duplicated or skipped byte.
  - Parity is still DD.
- Rejected commands: `start` with `dest=3` or with an empty buffer.
  - `cmd_err` pulses, `tx_active` stays 0, `pkt_valid` never rises, and `count` is unchanged.
- Full buffer: write 64 bytes of value `i`.
  - `count` stops at 63 and `buf_full=1`.
  - Transmission with `dest=2` produces header FE, 63 payload bytes, and parity = XOR of FE with bytes 0..62.
- Parity error injection: basic packet with `err_inject=1` at `start`.
  - Parity byte is DC.
- Reset mid-packet: assert `reset` on the second payload byte.
  - Outputs go to 0 and `count` to 0, with no `done`.
  - A new 1-byte packet with byte 55 and `dest=0` sends 04, 55, 51.

Source files
------------

// File: rtl/router_pkg.sv
// rtl/router_pkg.sv - shared types, constants and header packing for the router packet source
package router_pkg;

   localparam int MAX_LEN = 63;
   localparam logic [1:0] ADDR_INVALID = 2'b11;

   typedef enum logic [2:0] {
      S_IDLE,
      S_HEADER,
      S_PAYLOAD,
      S_PARITY,
      S_GAP
   } state_e;

   function automatic logic [7:0] pack_header(input logic [5:0] len, input logic [1:0] addr);
      return {len, addr};
   endfunction

endpackage

// File: rtl/router_tx_buf.sv
// rtl/router_tx_buf.sv - payload byte buffer with write-count pointer, async read and sync clear
module router_tx_buf #(
   parameter int MAX_LEN = 63
) (
   input  logic       clock,
   input  logic       reset,
   input  logic       wr_en,
   input  logic [7:0] wr_data,
   input  logic       clr,
   input  logic [5:0] rd_idx,
   output logic [7:0] rd_data,
   output logic [5:0] count,
   output logic       full
);

   logic [7:0] mem_q [MAX_LEN];
   logic [7:0] mem_d [MAX_LEN];
   logic [5:0] count_q, count_d;
   logic       full_q, full_d;
   logic       wr_fire;

   assign wr_fire = wr_en && !full_q && !clr;

   always_comb begin
      mem_d   = mem_q;
      count_d = count_q;
      if (clr) begin
         count_d = '0;
      end else if (wr_fire) begin
         mem_d[count_q] = wr_data;
         count_d        = count_q + 6'd1;
      end
      full_d = (count_d == 6'(MAX_LEN));
   end

   // Contents need no reset: a zero count makes every entry unreachable.
   always_ff @(posedge clock) begin
      mem_q <= mem_d;
   end

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         count_q <= '0;
         full_q  <= 1'b0;
      end else begin
         count_q <= count_d;
         full_q  <= full_d;
      end
   end

   assign rd_data = mem_q[rd_idx];
   assign count   = count_q;
   assign full    = full_q;

endmodule

// File: rtl/router_pkt_tx.sv
// rtl/router_pkt_tx.sv - buffers a host payload and emits one router packet (header, payload, parity) under busy back-pressure
module router_pkt_tx #(
   parameter int MAX_LEN = router_pkg::MAX_LEN,
   parameter int IFG     = 2
) (
   input  logic       clock,
   input  logic       reset,
   input  logic       wr_en,
   input  logic [7:0] wr_data,
   input  logic       start,
   input  logic [1:0] dest,
   input  logic       err_inject,
   input  logic       busy,
   output logic       pkt_valid,
   output logic [7:0] data_out,
   output logic [5:0] count,
   output logic       buf_full,
   output logic       tx_active,
   output logic       done,
   output logic       cmd_err
);
   import router_pkg::*;

   state_e     state_q, state_d;
   logic [7:0] data_q, data_d;
   logic       pv_q, pv_d;
   logic       tx_active_q, tx_active_d;
   logic       done_q, done_d;
   logic       cmd_err_q, cmd_err_d;
   logic [7:0] parity_q, parity_d;
   logic [5:0] idx_q, idx_d;
   logic       err_q, err_d;
   logic [7:0] gap_q, gap_d;

   logic       buf_wr, buf_clr, start_ok;
   logic [5:0] rd_idx;
   logic [7:0] rd_data, par_next;

   router_tx_buf #(.MAX_LEN(MAX_LEN)) u_buf (
      .clock   (clock),
      .reset   (reset),
      .wr_en   (buf_wr),
      .wr_data (wr_data),
      .clr     (buf_clr),
      .rd_idx  (rd_idx),
      .rd_data (rd_data),
      .count   (count),
      .full    (buf_full)
   );

   assign start_ok = start && (count != 6'd0) && (dest != ADDR_INVALID);
   // The read port looks one byte ahead so the next payload byte can be registered on transfer.
   assign rd_idx   = (state_q == S_HEADER) ? 6'd0 : idx_q + 6'd1;

   always_comb begin
      state_d     = state_q;
      data_d      = data_q;
      pv_d        = pv_q;
      tx_active_d = tx_active_q;
      done_d      = 1'b0;
      cmd_err_d   = 1'b0;
      parity_d    = parity_q;
      idx_d       = idx_q;
      err_d       = err_q;
      gap_d       = gap_q;
      buf_wr      = 1'b0;
      buf_clr     = 1'b0;
      par_next    = parity_q ^ data_q;

      case (state_q)
         S_IDLE: begin
            if (start && !start_ok) cmd_err_d = 1'b1;
            if (start_ok) begin
               state_d     = S_HEADER;
               data_d      = pack_header(count, dest);
               pv_d        = 1'b1;
               tx_active_d = 1'b1;
               parity_d    = pack_header(count, dest);
               err_d       = err_inject;
               idx_d       = '0;
            end else begin
               buf_wr = wr_en;
            end
         end
         S_HEADER: begin
            if (!busy) begin
               state_d = S_PAYLOAD;
               idx_d   = '0;
               data_d  = rd_data;
            end
         end
         S_PAYLOAD: begin
            if (!busy) begin
               parity_d = par_next;
               if (idx_q == count - 6'd1) begin
                  state_d = S_PARITY;
                  pv_d    = 1'b0;
                  data_d  = par_next ^ {7'b0, err_q};
               end else begin
                  idx_d  = idx_q + 6'd1;
                  data_d = rd_data;
               end
            end
         end
         S_PARITY: begin
            if (!busy) begin
               done_d  = 1'b1;
               buf_clr = 1'b1;
               state_d = S_GAP;
               data_d  = '0;
               gap_d   = '0;
            end
         end
         S_GAP: begin
            if (gap_q >= 8'(IFG - 1)) begin
               state_d     = S_IDLE;
               tx_active_d = 1'b0;
               gap_d       = '0;
            end else begin
               gap_d = gap_q + 8'd1;
            end
         end
         default: begin
            state_d     = S_IDLE;
            data_d      = '0;
            pv_d        = 1'b0;
            tx_active_d = 1'b0;
         end
      endcase
   end

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         state_q     <= S_IDLE;
         data_q      <= '0;
         pv_q        <= 1'b0;
         tx_active_q <= 1'b0;
         done_q      <= 1'b0;
         cmd_err_q   <= 1'b0;
         parity_q    <= '0;
         idx_q       <= '0;
         err_q       <= 1'b0;
         gap_q       <= '0;
      end else begin
         state_q     <= state_d;
         data_q      <= data_d;
         pv_q        <= pv_d;
         tx_active_q <= tx_active_d;
         done_q      <= done_d;
         cmd_err_q   <= cmd_err_d;
         parity_q    <= parity_d;
         idx_q       <= idx_d;
         err_q       <= err_d;
         gap_q       <= gap_d;
      end
   end

   assign pkt_valid = pv_q;
   assign data_out  = data_q;
   assign tx_active = tx_active_q;
   assign done      = done_q;
   assign cmd_err   = cmd_err_q;

endmodule

// File: tb/tb_router_pkt_tx.sv
// tb/tb_router_pkt_tx.sv - scoreboard bench for router_pkt_tx against a packet-level reference model
module tb_router_pkt_tx;

   localparam int IFG = 2;

   logic       clock = 1'b0;
   logic       reset = 1'b1;
   logic       wr_en = 1'b0;
   logic [7:0] wr_data = '0;
   logic       start = 1'b0;
   logic [1:0] dest = '0;
   logic       err_inject = 1'b0;
   logic       busy = 1'b0;
   logic       pkt_valid;
   logic [7:0] data_out;
   logic [5:0] count;
   logic       buf_full;
   logic       tx_active;
   logic       done;
   logic       cmd_err;

   router_pkt_tx #(.MAX_LEN(63), .IFG(IFG)) dut (
      .clock      (clock),
      .reset      (reset),
      .wr_en      (wr_en),
      .wr_data    (wr_data),
      .start      (start),
      .dest       (dest),
      .err_inject (err_inject),
      .busy       (busy),
      .pkt_valid  (pkt_valid),
      .data_out   (data_out),
      .count      (count),
      .buf_full   (buf_full),
      .tx_active  (tx_active),
      .done       (done),
      .cmd_err    (cmd_err)
   );

   always #5 clock = ~clock;

   typedef struct {
      logic [7:0] data;
      bit         is_par;
   } exp_t;

   exp_t       exp_q[$];
   logic [7:0] mdl_buf[$];
   int         n_checks = 0;
   int         n_pass = 0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
      n_checks++;
      if (act === req) n_pass++;
      else $display("FAIL %s: actual %0h required %0h", name, act, req);
   endtask

   task automatic fail_now(input string name);
      n_checks++;
      $display("FAIL %s: actual none required event", name);
   endtask

   // Monitor: predicts each byte transfer from the observed handshake and pops the model.
   exp_t       mon_e;
   logic [7:0] prev_data;
   logic       prev_pv, prev_busy;
   always @(negedge clock) begin
      if (reset) begin
         prev_data = '0;
         prev_pv   = 1'b0;
         prev_busy = 1'b0;
      end else begin
         if (prev_pv && prev_busy) begin
            check("hold_data", data_out, prev_data);
            check("hold_valid", pkt_valid, 1);
         end
         if (done) begin
            if (exp_q.size() == 0) fail_now("sb_underflow_parity");
            else begin
               mon_e = exp_q.pop_front();
               check("sb_kind_parity", mon_e.is_par, 1);
               check("sb_parity", prev_data, mon_e.data);
               check("parity_valid_low", prev_pv, 0);
            end
         end
         if (pkt_valid && !busy) begin
            if (exp_q.size() == 0) fail_now("sb_underflow_byte");
            else begin
               mon_e = exp_q.pop_front();
               check("sb_kind_byte", mon_e.is_par, 0);
               check("sb_byte", data_out, mon_e.data);
            end
         end
         prev_data = data_out;
         prev_pv   = pkt_valid;
         prev_busy = busy;
      end
   end

   task automatic cyc();
      @(posedge clock);
      #1;
   endtask

   task automatic wr(input logic [7:0] b);
      wr_en = 1'b1;
      wr_data = b;
      cyc();
      wr_en = 1'b0;
      if (mdl_buf.size() < 63) mdl_buf.push_back(b);
   endtask

   // Reference packet: header {len,dest}, buffered bytes, XOR of all (LSB flipped on error injection).
   task automatic load_expect(input logic [1:0] d, input bit e, output logic [7:0] hdr, output int n);
      logic [7:0] par;
      n = mdl_buf.size();
      hdr = {n[5:0], d};
      par = hdr;
      exp_q.push_back('{hdr, 1'b0});
      foreach (mdl_buf[i]) begin
         par ^= mdl_buf[i];
         exp_q.push_back('{mdl_buf[i], 1'b0});
      end
      exp_q.push_back('{par ^ {7'b0, e}, 1'b1});
      mdl_buf.delete();
   endtask

   task automatic send(input logic [1:0] d, input bit e, input bit rb, input bit rw, input bit ws);
      logic [7:0] hdr;
      int n, cycles, g;
      bit got;
      load_expect(d, e, hdr, n);
      start = 1'b1; dest = d; err_inject = e;
      wr_en = ws; wr_data = 8'h44;
      cyc();
      start = 1'b0; err_inject = 1'b0; wr_en = 1'b0;
      check("hdr_valid", pkt_valid, 1);
      check("hdr_data", data_out, hdr);
      got = 0;
      cycles = 0;
      for (int i = 0; i < 2000 && !got; i++) begin
         busy = rb ? ($urandom_range(0, 3) == 0) : 1'b0;
         wr_en = rw ? 1'($urandom_range(0, 1)) : 1'b0;
         wr_data = 8'($urandom);
         cyc();
         cycles++;
         got = done;
      end
      busy = 1'b0;
      wr_en = 1'b0;
      if (!got) fail_now("done_timeout");
      else begin
         check("count_cleared", count, 0);
         if (!rb) check("pkt_cycles", cycles, n + 2);
      end
      g = 0;
      for (int i = 0; i < 50 && tx_active; i++) begin
         cyc();
         g++;
      end
      check("tx_idle", tx_active, 0);
      if (!rb) check("gap_cycles", g, IFG);
   endtask

   initial begin
      logic [7:0] hdr;
      int n, held;
      bit seen;

      repeat (3) cyc();
      reset = 1'b0;
      cyc();
      check("rst_pkt_valid", pkt_valid, 0);
      check("rst_data_out", data_out, 0);
      check("rst_count", count, 0);
      check("rst_buf_full", buf_full, 0);
      check("rst_tx_active", tx_active, 0);
      check("rst_done", done, 0);
      check("rst_cmd_err", cmd_err, 0);

      // Basic packet.
      wr(8'hA1); wr(8'hB2); wr(8'hC3);
      check("basic_count", count, 3);
      send(2'd1, 1'b0, 1'b0, 1'b0, 1'b0);

      // Back-pressure while B2 is presented.
      wr(8'hA1); wr(8'hB2); wr(8'hC3);
      load_expect(2'd1, 1'b0, hdr, n);
      start = 1'b1; dest = 2'd1;
      cyc();
      start = 1'b0;
      seen = 0;
      for (int i = 0; i < 20 && !seen; i++) begin
         if (pkt_valid && data_out == 8'hB2) seen = 1;
         else cyc();
      end
      if (!seen) fail_now("bp_b2_timeout");
      held = 1;
      busy = 1'b1;
      for (int i = 0; i < 3; i++) begin
         cyc();
         if (pkt_valid && data_out == 8'hB2) held++;
      end
      busy = 1'b0;
      cyc();
      check("bp_b2_hold_cycles", held, 4);
      for (int i = 0; i < 50 && tx_active; i++) cyc();
      check("bp_idle", tx_active, 0);
      check("bp_count", count, 0);

      // Rejected commands.
      start = 1'b1; dest = 2'd0;
      cyc();
      start = 1'b0;
      check("rej_empty_cmd_err", cmd_err, 1);
      check("rej_empty_tx", tx_active, 0);
      check("rej_empty_valid", pkt_valid, 0);
      check("rej_empty_count", count, 0);
      cyc();
      check("rej_pulse_end", cmd_err, 0);
      wr(8'h11); wr(8'h22);
      start = 1'b1; dest = 2'd3; wr_en = 1'b1; wr_data = 8'h33;
      cyc();
      start = 1'b0; wr_en = 1'b0;
      mdl_buf.push_back(8'h33);
      check("rej_dest_cmd_err", cmd_err, 1);
      check("rej_dest_tx", tx_active, 0);
      check("rej_dest_valid", pkt_valid, 0);
      check("rej_dest_write_kept", count, 3);
      // Legal start with a simultaneous write: the write must be dropped.
      send(2'd0, 1'b0, 1'b0, 1'b0, 1'b1);

      // Full buffer.
      for (int i = 0; i < 64; i++) begin
         wr(8'(i));
         if (i == 61) check("full_not_yet", buf_full, 0);
      end
      check("full_count", count, 63);
      check("full_flag", buf_full, 1);
      send(2'd2, 1'b0, 1'b1, 1'b0, 1'b0);
      check("full_flag_cleared", buf_full, 0);

      // Parity error injection.
      wr(8'hA1); wr(8'hB2); wr(8'hC3);
      send(2'd1, 1'b1, 1'b0, 1'b0, 1'b0);

      // Randomized packets with random busy and ignored writes during transmission.
      for (int p = 0; p < 6; p++) begin
         int len;
         len = $urandom_range(1, 63);
         for (int i = 0; i < len; i++) wr(8'($urandom));
         send(2'($urandom_range(0, 2)), 1'($urandom_range(0, 1)), 1'b1, 1'b1, 1'b0);
      end

      // Reset on the second payload byte.
      wr(8'hA1); wr(8'hB2); wr(8'hC3);
      load_expect(2'd1, 1'b0, hdr, n);
      start = 1'b1; dest = 2'd1;
      cyc();
      start = 1'b0;
      seen = 0;
      for (int i = 0; i < 20 && !seen; i++) begin
         if (pkt_valid && data_out == 8'hB2) seen = 1;
         else cyc();
      end
      if (!seen) fail_now("rst_b2_timeout");
      exp_q.delete();
      reset = 1'b1;
      #1;
      check("midrst_valid", pkt_valid, 0);
      check("midrst_data", data_out, 0);
      check("midrst_count", count, 0);
      check("midrst_tx", tx_active, 0);
      cyc();
      reset = 1'b0;
      for (int i = 0; i < 4; i++) begin
         cyc();
         check("midrst_no_done", done, 0);
      end
      wr(8'h55);
      send(2'd0, 1'b0, 1'b0, 1'b0, 1'b0);

      repeat (3) cyc();
      check("sb_empty", exp_q.size(), 0);
      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
